demux_capture_bank: RTL

- Downstream stage of the 1x32 demultiplexer: captures the demux output bit selected by sel on each write strobe into a shadow register.
- Once all 32 positions have been written, presents the assembled word on a valid/ready output port.
- Converts the demux's serial bit-per-channel traffic into parallel 32-bit words for the consuming logic.

---
 rtl/demux_capture_bank.sv | 91 +++++++++
 1 files changed

// File: rtl/demux_capture_bank.sv
// Collects one demux output bit per write strobe into a 32-bit word and hands it off on a valid/ready port.
// Optional demux one-hot check is built only with DEMUX_CHECK_EN defined.
module demux_capture_bank #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] y,
  input  logic             clr,
  output logic             busy,
  output logic [WIDTH-1:0] fill_mask,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overwrite_err,
  output logic             glitch_err
);

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] onehot;
  logic [WIDTH-1:0] merged_shadow;
  logic [WIDTH-1:0] merged_mask;
  logic             accept;
  logic             complete;
  logic             consumed;

  assign onehot        = {{(WIDTH-1){1'b0}}, 1'b1} << sel;
  assign busy          = (state == STALL);
  assign accept        = wr_en & ~busy & ~clr;
  assign merged_shadow = y[sel] ? (shadow | onehot) : (shadow & ~onehot);
  assign merged_mask   = fill_mask | onehot;
  assign complete      = accept & (&merged_mask);
  assign consumed      = word_valid & word_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= FILL;
      shadow        <= '0;
      fill_mask     <= '0;
      word          <= '0;
      word_valid    <= 1'b0;
      overwrite_err <= 1'b0;
    end else begin
      // A load later in this block overrides the consume-driven drop of valid.
      if (consumed) word_valid <= 1'b0;
      if (clr) begin
        shadow    <= '0;
        fill_mask <= '0;
        state     <= FILL;
      end else if (state == STALL) begin
        if (word_ready) begin
          word       <= shadow;
          word_valid <= 1'b1;
          shadow     <= '0;
          fill_mask  <= '0;
          state      <= FILL;
        end
      end else if (accept) begin
        if (fill_mask[sel]) overwrite_err <= 1'b1;
        if (complete && (!word_valid || word_ready)) begin
          word       <= merged_shadow;
          word_valid <= 1'b1;
          shadow     <= '0;
          fill_mask  <= '0;
        end else begin
          shadow    <= merged_shadow;
          fill_mask <= merged_mask;
          if (complete) state <= STALL;
        end
      end
    end
  end

`ifdef DEMUX_CHECK_EN
  // Any set bit besides the selected channel breaks the demux one-hot-or-zero contract.
  always_ff @(posedge clk) begin
    if (!rst_n) glitch_err <= 1'b0;
    else if (accept && |(y & ~onehot)) glitch_err <= 1'b1;
  end
`else
  assign glitch_err = 1'b0;
`endif

endmodule
